// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters via valid/ready handshakes.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*OP_WIDTH-1:0]   req_operation,
  input  logic [2*DATA_WIDTH-1:0] req_operand_1,
  input  logic [2*DATA_WIDTH-1:0] req_operand_2,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_error,
  output logic [OP_WIDTH-1:0]     alu_operation,
  output logic [DATA_WIDTH-1:0]   alu_operand_1,
  output logic [DATA_WIDTH-1:0]   alu_operand_2,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  output logic                    busy
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // A request holds valid and its payload until accepted; a response holds until rsp_ready.
  localparam logic [OP_WIDTH-1:0] ALU_AND = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_OR  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALU_ADD = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALU_XOR = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALU_SUB = OP_WIDTH'(6);

  typedef enum logic [1:0] {IDLE, EXECUTE, RESPOND} state_t;

  state_t state_q, state_d;
  logic   grant_q;
  logic   pick;
  logic   accept;
  logic   rsp_done;
  logic   op_illegal;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  // On contention the pointer wins; a lone valid request always wins.
  assign pick = req_valid[1] & (~req_valid[0] | ptr_q);
`else
  assign pick = req_valid[1] & ~req_valid[0];
`endif

  assign req_ready  = (state_q == IDLE && rst_n) ? ({pick, ~pick} & req_valid) : 2'b00;
  assign accept     = |req_ready;
  assign rsp_valid  = (state_q == RESPOND) ? {grant_q, ~grant_q} : 2'b00;
  assign rsp_done   = (state_q == RESPOND) && rsp_ready[grant_q];
  assign busy       = (state_q != IDLE);
  assign op_illegal = !(alu_operation inside {ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXECUTE;
      EXECUTE: state_d = RESPOND;
      RESPOND: if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs are only loaded on an accepted request and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= 1'b0;
      alu_operation <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
    end else if (accept) begin
      grant_q       <= pick;
      alu_operation <= pick ? req_operation[2*OP_WIDTH-1:OP_WIDTH] : req_operation[OP_WIDTH-1:0];
      alu_operand_1 <= pick ? req_operand_1[2*DATA_WIDTH-1:DATA_WIDTH] : req_operand_1[DATA_WIDTH-1:0];
      alu_operand_2 <= pick ? req_operand_2[2*DATA_WIDTH-1:DATA_WIDTH] : req_operand_2[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
    end else if (state_q == EXECUTE) begin
      rsp_result <= op_illegal ? '0 : alu_result;
      rsp_zero   <= op_illegal ? 1'b0 : alu_zero;
      rsp_error  <= op_illegal;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= 1'b0;
    else if (rsp_done) ptr_q <= ~grant_q;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; models the combinational ALU and checks each scenario inline.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam logic [OW-1:0] OP_AND = 3'd0;
  localparam logic [OW-1:0] OP_OR  = 3'd1;
  localparam logic [OW-1:0] OP_ADD = 3'd2;
  localparam logic [OW-1:0] OP_XOR = 3'd3;
  localparam logic [OW-1:0] OP_SUB = 3'd6;
  localparam logic [OW-1:0] OP_BAD = 3'd7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*OW-1:0] req_operation = '0;
  logic [2*DW-1:0] req_operand_1 = '0;
  logic [2*DW-1:0] req_operand_2 = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = 2'b11;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            rsp_error;
  logic [OW-1:0]   alu_operation;
  logic [DW-1:0]   alu_operand_1;
  logic [DW-1:0]   alu_operand_2;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;
  logic            busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_error(rsp_error),
    .alu_operation(alu_operation), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model; illegal codes yield a nonzero result with zero set so forcing to 0 is visible.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_operation)
      OP_AND: alu_result = alu_operand_1 & alu_operand_2;
      OP_OR:  alu_result = alu_operand_1 | alu_operand_2;
      OP_ADD: alu_result = alu_operand_1 + alu_operand_2;
      OP_XOR: alu_result = alu_operand_1 ^ alu_operand_2;
      OP_SUB: alu_result = alu_operand_1 - alu_operand_2;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_operation inside {OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB}) ? (alu_result == '0) : 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load(input int port, input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (port == 0) begin
      req_operation[OW-1:0] = op; req_operand_1[DW-1:0] = a; req_operand_2[DW-1:0] = b;
    end else begin
      req_operation[2*OW-1:OW] = op; req_operand_1[2*DW-1:DW] = a; req_operand_2[2*DW-1:DW] = b;
    end
  endtask

  // Drives one request and returns after the accepting edge (DUT in EXECUTE); ok=0 on timeout.
  task automatic issue(input int port, input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, output bit ok);
    load(port, op, a, b);
    req_valid[port] = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[port]) begin ok = 1'b1; break; end
      step();
    end
    step();
    req_valid[port] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({req_ready, rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {req_ready, rsp_valid, busy}); end
    checks++; if ({rsp_result, rsp_zero, rsp_error} !== 34'b0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_result, rsp_zero, rsp_error}); end
    checks++; if ({alu_operation, alu_operand_1, alu_operand_2} !== 67'b0) begin errors++; $display("FAIL reset_alu: got %h expected 0", {alu_operation, alu_operand_1, alu_operand_2}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    bit ok;
    rsp_ready = 2'b11;
    load(0, OP_ADD, 32'd5, 32'd7);
    req_valid[0] = 1'b1;
    #1;
    checks++; if ({req_ready, busy} !== 3'b010) begin errors++; $display("FAIL add_ready: got %b expected 010", {req_ready, busy}); end
    issue(0, OP_ADD, 32'd5, 32'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_timeout: got no handshake expected handshake"); end
    checks++; if ({busy, rsp_valid, alu_operand_1, alu_operand_2} !== {1'b1, 2'b00, 32'd5, 32'd7}) begin errors++; $display("FAIL add_execute: got busy=%b v=%b a=%h b=%h expected 1 00 5 7", busy, rsp_valid, alu_operand_1, alu_operand_2); end
    step();
    checks++; if ({busy, rsp_valid, req_ready} !== 5'b10100) begin errors++; $display("FAIL add_respond: got %b expected 10100", {busy, rsp_valid, req_ready}); end
    checks++; if ({rsp_result, rsp_zero, rsp_error} !== {32'd12, 2'b00}) begin errors++; $display("FAIL add_result: got %h z=%b e=%b expected 0000000c 0 0", rsp_result, rsp_zero, rsp_error); end
    step();
    checks++; if ({busy, rsp_valid} !== 3'b000) begin errors++; $display("FAIL add_idle: got %b expected 000", {busy, rsp_valid}); end
  endtask

  task automatic test_sub_zero();
    bit ok;
    issue(1, OP_SUB, 32'h1234, 32'h1234, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sub_timeout: got no handshake expected handshake"); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL sub_valid: got %b expected 10", rsp_valid); end
    checks++; if ({rsp_result, rsp_zero, rsp_error} !== {32'd0, 2'b10}) begin errors++; $display("FAIL sub_result: got %h z=%b e=%b expected 0 1 0", rsp_result, rsp_zero, rsp_error); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    bit ok;
    apply_reset();
    load(0, OP_ADD, 32'd3, 32'd4);
    load(1, OP_XOR, 32'hF0, 32'h0F);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (req_ready != 2'b00) begin ok = 1'b1; break; end
        step();
      end
      checks++; if (!ok || req_ready !== exp_g) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp_g); end
      step();
      step();
      checks++; if (rsp_valid !== exp_g || rsp_result !== ((exp_g == 2'b01) ? 32'd7 : 32'hFF)) begin errors++; $display("FAIL contention_rsp%0d: got v=%b r=%h expected %b", i, rsp_valid, rsp_result, exp_g); end
      step();
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_ready = 2'b00;
    issue(0, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no handshake expected handshake"); end
    load(1, OP_ADD, 32'd1, 32'd1);
    req_valid[1] = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({rsp_valid, req_ready, busy} !== 5'b01001 || rsp_result !== 32'hF0F0_0F0F) begin errors++; $display("FAIL bp_hold%0d: got v=%b rdy=%b busy=%b r=%h expected 01 00 1 f0f00f0f", k, rsp_valid, req_ready, busy, rsp_result); end
      step();
    end
    rsp_ready = 2'b01;
    step();
    checks++; if ({busy, rsp_valid, req_ready} !== 5'b00010) begin errors++; $display("FAIL bp_release: got %b expected 00010", {busy, rsp_valid, req_ready}); end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
  endtask

  task automatic test_illegal();
    bit ok;
    issue(1, OP_BAD, 32'd9, 32'd9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_timeout: got no handshake expected handshake"); end
    step();
    checks++; if ({rsp_valid, rsp_result, rsp_zero, rsp_error} !== {2'b10, 32'd0, 2'b01}) begin errors++; $display("FAIL illegal_rsp: got v=%b r=%h z=%b e=%b expected 10 0 0 1", rsp_valid, rsp_result, rsp_zero, rsp_error); end
    step();
    issue(0, OP_AND, 32'hFF, 32'h0F, ok);
    step();
    checks++; if (!ok || {rsp_valid, rsp_result, rsp_zero, rsp_error} !== {2'b01, 32'h0F, 2'b00}) begin errors++; $display("FAIL illegal_next: got v=%b r=%h z=%b e=%b expected 01 f 0 0", rsp_valid, rsp_result, rsp_zero, rsp_error); end
    step();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    issue(0, OP_ADD, 32'd100, 32'd23, ok);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, req_ready, rsp_error, rsp_zero} !== 7'b0 || {rsp_result, alu_operation, alu_operand_1, alu_operand_2} !== 99'b0) begin errors++; $display("FAIL midreset_outputs: got busy=%b v=%b op1=%h expected all 0", busy, rsp_valid, alu_operand_1); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({rsp_valid, busy} !== 3'b000) begin errors++; $display("FAIL midreset_stale%0d: got %b expected 000", k, {rsp_valid, busy}); end
    end
    issue(0, OP_OR, 32'hA0, 32'h0B, ok);
    step();
    checks++; if (!ok || rsp_valid !== 2'b01 || rsp_result !== 32'hAB) begin errors++; $display("FAIL midreset_or: got v=%b r=%h expected 01 000000ab", rsp_valid, rsp_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
